// File: rtl/nios_cutecar_pio_pkg.sv
// Shared constants for the Cutecar Nios input PIO: register map, edge-select
// encodings and the debounce counter sizing helper.
package nios_cutecar_pio_pkg;

  localparam logic [1:0] ADDR_DATA     = 2'd0;
  localparam logic [1:0] ADDR_RESERVED = 2'd1;
  localparam logic [1:0] ADDR_IRQMASK  = 2'd2;
  localparam logic [1:0] ADDR_EDGECAP  = 2'd3;

  localparam int EDGE_RISING  = 32'sd0;
  localparam int EDGE_FALLING = 32'sd1;
  localparam int EDGE_ANY     = 32'sd2;

  // Counter must be able to hold DEBOUNCE_CYCLES itself, hence the +1.
  function automatic int debounce_cnt_width(input int cycles);
    return $clog2(cycles + 32'sd1);
  endfunction

endpackage

// File: rtl/nios_cutecar_debounce.sv
// One input bit: two-flop synchroniser followed by a hold-time debounce filter.
// stable only moves after sync1 has held the new level for DEBOUNCE_CYCLES clocks.
module nios_cutecar_debounce
  import nios_cutecar_pio_pkg::*;
#(
  parameter int   DEBOUNCE_CYCLES = 50000,
  parameter logic RESET_BIT       = 1'b1
) (
  input  logic clk,
  input  logic reset_n,
  input  logic din,
  output logic stable
);

  localparam int            CW       = debounce_cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_ZERO = CW'(0);

  logic          sync0_r;
  logic          sync1_r;
  logic          stable_r;
  logic [CW-1:0] cnt_r;

  // Synchroniser chain, hold counter and accepted level.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync0_r  <= RESET_BIT;
      sync1_r  <= RESET_BIT;
      stable_r <= RESET_BIT;
      cnt_r    <= CNT_ZERO;
    end else begin
      sync0_r <= din;
      sync1_r <= sync0_r;
      if (sync1_r == stable_r) begin
        cnt_r <= CNT_ZERO;
      end else if (cnt_r == CNT_LAST) begin
        stable_r <= sync1_r;
        cnt_r    <= CNT_ZERO;
      end else begin
        cnt_r <= cnt_r + CNT_ONE;
      end
    end
  end

  assign stable = stable_r;

endmodule

// File: rtl/nios_cutecar_buttons_pio.sv
// Avalon-MM input PIO for the Cutecar buttons/switches: debounced DATA,
// write-1-to-clear edge capture and a maskable, registered level interrupt.
module nios_cutecar_buttons_pio
  import nios_cutecar_pio_pkg::*;
#(
  parameter int               WIDTH           = 4,
  parameter int               DEBOUNCE_CYCLES = 50000,
  parameter int               EDGE_TYPE       = EDGE_FALLING,
  parameter logic [WIDTH-1:0] RESET_LEVEL     = {WIDTH{1'b1}}
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  input  logic [WIDTH-1:0] in_port,
  output logic [31:0]      readdata,
  output logic             irq
);

  logic [WIDTH-1:0] stable_s;
  logic [WIDTH-1:0] rise_s;
  logic [WIDTH-1:0] fall_s;
  logic [WIDTH-1:0] edge_s;
  logic [WIDTH-1:0] clr_s;
  logic             bus_wr_s;
  logic             mask_wr_s;
  logic [31:0]      rd_s;
  logic             wd_unused_s;

  logic [WIDTH-1:0] stable_d_r;
  logic [WIDTH-1:0] irqmask_r;
  logic [WIDTH-1:0] edgecap_r;
  logic             irq_r;

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    nios_cutecar_debounce #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .RESET_BIT       (RESET_LEVEL[i])
    ) u_debounce (
      .clk     (clk),
      .reset_n (reset_n),
      .din     (in_port[i]),
      .stable  (stable_s[i])
    );
  end

  // Edge detect on the debounced level and selection of the captured edge.
  always_comb begin
    rise_s = stable_s & ~stable_d_r;
    fall_s = ~stable_s & stable_d_r;
    case (EDGE_TYPE)
      EDGE_RISING:  edge_s = rise_s;
      EDGE_FALLING: edge_s = fall_s;
      EDGE_ANY:     edge_s = rise_s | fall_s;
      default:      edge_s = {WIDTH{1'b0}};
    endcase
  end

  // Bus write decode; clear mask only exists during an EDGECAP write.
  always_comb begin
    bus_wr_s  = chipselect & ~write_n;
    mask_wr_s = 1'b0;
    clr_s     = {WIDTH{1'b0}};
    if (bus_wr_s && (address == ADDR_IRQMASK)) begin
      mask_wr_s = 1'b1;
    end else begin
      mask_wr_s = 1'b0;
    end
    if (bus_wr_s && (address == ADDR_EDGECAP)) begin
      clr_s = writedata[WIDTH-1:0];
    end else begin
      clr_s = {WIDTH{1'b0}};
    end
  end

  // Register file; a new edge overrides a same-cycle clear so it is never lost.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stable_d_r <= RESET_LEVEL;
      irqmask_r  <= {WIDTH{1'b0}};
      edgecap_r  <= {WIDTH{1'b0}};
      irq_r      <= 1'b0;
    end else begin
      stable_d_r <= stable_s;
      if (mask_wr_s) begin
        irqmask_r <= writedata[WIDTH-1:0];
      end else begin
        irqmask_r <= irqmask_r;
      end
      edgecap_r <= (edgecap_r & ~clr_s) | edge_s;
      irq_r     <= |(edgecap_r & irqmask_r);
    end
  end

  // Zero-wait-state read mux, zero-extended to the 32-bit bus.
  always_comb begin
    rd_s = 32'd0;
    case (address)
      ADDR_DATA:     rd_s[WIDTH-1:0] = stable_s;
      ADDR_RESERVED: rd_s = 32'd0;
      ADDR_IRQMASK:  rd_s[WIDTH-1:0] = irqmask_r;
      ADDR_EDGECAP:  rd_s[WIDTH-1:0] = edgecap_r;
      default:       rd_s = 32'd0;
    endcase
  end

  assign wd_unused_s = ^writedata;
  assign readdata    = rd_s;
  assign irq         = irq_r;

endmodule

// File: tb/tb_nios_cutecar_buttons_pio.sv
// Scoreboard bench: three PIO instances (rising/falling/any) share one bus and input
// stream; a window-based reference model predicts reads and irq, a monitor compares.
module tb_nios_cutecar_buttons_pio;

  localparam int W  = 4;
  localparam int D  = 4;
  localparam int HL = D + 2;

  typedef struct packed {
    logic [1:0]       addr;
    logic [2:0][31:0] want;
  } rd_exp_t;

  logic          clk = 1'b0;
  logic          reset_n;
  logic [1:0]    address;
  logic          chipselect;
  logic          write_n;
  logic [31:0]   writedata;
  logic [W-1:0]  in_port;
  logic [31:0]   rd_rise, rd_fall, rd_any;
  logic          irq_rise, irq_fall, irq_any;

  int checks = 0;
  int errors = 0;

  // Model state
  logic [W-1:0] hist [$];
  logic [W-1:0] stable_m, mask_m, pend_rise, pend_fall;
  logic [W-1:0] ec_m [3];
  logic [2:0]   irq_m;
  logic [2:0]   irq_q [$];
  rd_exp_t      rd_q [$];
  logic [W-1:0] cur;

  always #5 clk = ~clk;

  nios_cutecar_buttons_pio #(.WIDTH(W), .DEBOUNCE_CYCLES(D), .EDGE_TYPE(0)) u_dut_rise (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect), .write_n(write_n),
    .writedata(writedata), .in_port(in_port), .readdata(rd_rise), .irq(irq_rise));
  nios_cutecar_buttons_pio #(.WIDTH(W), .DEBOUNCE_CYCLES(D), .EDGE_TYPE(1)) u_dut_fall (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect), .write_n(write_n),
    .writedata(writedata), .in_port(in_port), .readdata(rd_fall), .irq(irq_fall));
  nios_cutecar_buttons_pio #(.WIDTH(W), .DEBOUNCE_CYCLES(D), .EDGE_TYPE(2)) u_dut_any (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect), .write_n(write_n),
    .writedata(writedata), .in_port(in_port), .readdata(rd_any), .irq(irq_any));

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", nm, act, want);
    end
  endtask

  task automatic model_reset();
    hist.delete();
    for (int i = 0; i < HL; i++) hist.push_back({W{1'b1}});
    stable_m  = {W{1'b1}};
    mask_m    = '0;
    pend_rise = '0;
    pend_fall = '0;
    for (int t = 0; t < 3; t++) ec_m[t] = '0;
    irq_m = '0;
    irq_q.delete();
    rd_q.delete();
  endtask

  // One clock edge of the reference model, using the inputs currently applied.
  task automatic model_tick();
    logic [W-1:0] clr, sel, win_and, win_or, flip;
    logic wr;
    wr = chipselect && !write_n;
    for (int t = 0; t < 3; t++) irq_m[t] = |(ec_m[t] & mask_m);
    clr = (wr && address == 2'd3) ? writedata[W-1:0] : '0;
    for (int t = 0; t < 3; t++) begin
      sel = (t == 0) ? pend_rise : (t == 1) ? pend_fall : (pend_rise | pend_fall);
      ec_m[t] = (ec_m[t] & ~clr) | sel;
    end
    if (wr && address == 2'd2) mask_m = writedata[W-1:0];
    hist.push_back(in_port);
    void'(hist.pop_front());
    // Window = the D input samples that are now two flops deep; a bit flips
    // once the whole window sits at the opposite level.
    win_and = '1;
    win_or  = '0;
    for (int i = 0; i < D; i++) begin
      win_and &= hist[i];
      win_or  |= hist[i];
    end
    flip      = (win_and & ~stable_m) | (~win_or & stable_m);
    pend_rise = flip & ~stable_m;
    pend_fall = flip & stable_m;
    stable_m  = stable_m ^ flip;
    irq_q.push_back(irq_m);
  endtask

  function automatic logic [31:0] exp_rd(input int t, input logic [1:0] a);
    logic [31:0] v;
    v = 32'd0;
    case (a)
      2'd0:    v[W-1:0] = stable_m;
      2'd2:    v[W-1:0] = mask_m;
      2'd3:    v[W-1:0] = ec_m[t];
      default: v = 32'd0;
    endcase
    return v;
  endfunction

  task automatic step(input logic [W-1:0] inp, input logic cs, input logic wr,
                      input logic [1:0] a, input logic [31:0] wd);
    rd_exp_t e;
    @(posedge clk);
    model_tick();
    #1;
    in_port    = inp;
    chipselect = cs;
    write_n    = ~wr;
    address    = a;
    writedata  = wd;
    if (cs && !wr) begin
      e.addr = a;
      for (int t = 0; t < 3; t++) e.want[t] = exp_rd(t, a);
      rd_q.push_back(e);
    end
  endtask

  task automatic rd(input logic [1:0] a);
    step(cur, 1'b1, 1'b0, a, 32'd0);
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] wd);
    step(cur, 1'b1, 1'b1, a, wd);
  endtask

  task automatic reset_check(input string tag);
    logic [31:0] want;
    @(posedge clk);
    #2;
    reset_n    = 1'b0;
    chipselect = 1'b1;
    write_n    = 1'b1;
    writedata  = 32'd0;
    model_reset();
    #1;
    chk({tag, "_irq"}, {29'd0, irq_rise, irq_fall, irq_any}, 32'd0);
    for (int a = 0; a < 4; a++) begin
      address = 2'(a);
      #1;
      want = (a == 0) ? 32'h0000_000F : 32'd0;
      chk($sformatf("%s_rise_a%0d", tag, a), rd_rise, want);
      chk($sformatf("%s_fall_a%0d", tag, a), rd_fall, want);
      chk($sformatf("%s_any_a%0d", tag, a), rd_any, want);
    end
    chipselect = 1'b0;
    @(negedge clk);
    #1;
    reset_n = 1'b1;
  endtask

  // Monitor: compare irq every cycle and readdata whenever a read is on the bus.
  initial begin
    logic [2:0] ie;
    rd_exp_t    re;
    forever begin
      @(negedge clk);
      if (reset_n) begin
        if (irq_q.size() > 0) begin
          ie = irq_q.pop_front();
          chk("irq_rise", {31'd0, irq_rise}, {31'd0, ie[0]});
          chk("irq_fall", {31'd0, irq_fall}, {31'd0, ie[1]});
          chk("irq_any",  {31'd0, irq_any},  {31'd0, ie[2]});
        end
        if (chipselect && write_n) begin
          checks++;
          if (rd_q.size() == 0) begin
            errors++;
            $display("FAIL rd_queue_empty actual=0 expected=1");
          end else begin
            checks--;
            re = rd_q.pop_front();
            chk($sformatf("rd_rise_a%0d", re.addr), rd_rise, re.want[0]);
            chk($sformatf("rd_fall_a%0d", re.addr), rd_fall, re.want[1]);
            chk($sformatf("rd_any_a%0d", re.addr),  rd_any,  re.want[2]);
          end
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n    = 1'b0;
    chipselect = 1'b0;
    write_n    = 1'b1;
    address    = 2'd0;
    writedata  = 32'd0;
    cur        = 4'hF;
    in_port    = cur;
    model_reset();
    reset_check("reset");

    // Bit 0 press held: DATA follows after the debounce latency, then EDGECAP.
    cur = 4'hE;
    step(cur, 1'b1, 1'b0, 2'd0, 32'd0);
    for (int i = 0; i < 6; i++) rd(2'd0);
    rd(2'd3);
    rd(2'd3);
    // Bit 1 glitch of three cycles must be filtered.
    cur = 4'hC;
    for (int i = 0; i < 3; i++) step(cur, 1'b1, 1'b0, 2'd0, 32'd0);
    cur = 4'hE;
    for (int i = 0; i < 8; i++) rd(2'(i % 2 == 0 ? 0 : 3));

    // Unmask, clear, no-op clear.
    wr(2'd2, 32'h1);
    for (int i = 0; i < 3; i++) rd(2'd3);
    wr(2'd3, 32'h1);
    for (int i = 0; i < 3; i++) rd(2'd3);
    wr(2'd3, 32'h0);
    rd(2'd3);
    rd(2'd2);

    // Clear of bit 2 lands on the same edge that captures its fall.
    cur = 4'hA;
    step(cur, 1'b1, 1'b0, 2'd0, 32'd0);
    for (int i = 0; i < 5; i++) rd(2'd0);
    wr(2'd3, 32'h4);
    rd(2'd3);
    rd(2'd3);

    // Bit 3 press then release: edge-type dependent capture.
    wr(2'd3, 32'hF);
    cur = 4'h2;
    for (int i = 0; i < 8; i++) step(cur, 1'b1, 1'b0, 2'd3, 32'd0);
    cur = 4'hA;
    for (int i = 0; i < 8; i++) step(cur, 1'b1, 1'b0, 2'd3, 32'd0);

    // DATA is read-only, address 1 reads zero, full-width writes leave upper bits clear.
    wr(2'd0, 32'h5);
    rd(2'd1);
    rd(2'd0);
    wr(2'd2, 32'hFFFF_FFFF);
    rd(2'd2);

    // Reset with counters mid-run and registers populated.
    cur = 4'h5;
    step(cur, 1'b1, 1'b0, 2'd3, 32'd0);
    rd(2'd0);
    reset_check("midreset");
    for (int i = 0; i < 8; i++) rd(2'(i % 4));

    // Randomized traffic.
    for (int n = 0; n < 1500; n++) begin
      for (int b = 0; b < W; b++) if ($urandom_range(7) == 0) cur[b] = ~cur[b];
      step(cur, ($urandom_range(9) != 0), ($urandom_range(3) == 0),
           2'($urandom_range(3)), $urandom);
    end

    for (int i = 0; i < 3; i++) step(cur, 1'b0, 1'b0, 2'd0, 32'd0);
    @(negedge clk);
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
